led_fill_drain_gen: RTL

//   Parametrised LED fill/drain pattern generator ("sang dan tat dan"): lights WIDTH LEDs one

---
 rtl/led_fill_drain_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/led_fill_drain_gen.sv
// rtl/led_fill_drain_gen.sv - LED fill/drain pattern generator with modes, prescaler and event pulses (optional LED_FILL_HOLD_EN adds a dwell at full)
module led_fill_drain_gen #(
    parameter int WIDTH      = 8,
    parameter int DIV_W      = 24,
    parameter int HOLD_TICKS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [DIV_W-1:0] DIV,
    output logic [WIDTH-1:0] Q,
    output logic             FULL_PULSE,
    output logic             EMPTY_PULSE
);

    localparam int H = WIDTH / 2;
    localparam logic [H-1:0] HALF_ONE = H'(1);
    localparam logic [H-1:0] HALF_TOP = HALF_ONE << (H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [1:0]       mode_r;
    logic [DIV_W-1:0] cnt;
    logic             tick;
    logic [WIDTH-1:0] fill_q;
    logic [WIDTH-1:0] drain_q;
    logic [H-1:0]     lo;
    logic [H-1:0]     hi;

`ifdef LED_FILL_HOLD_EN
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    logic [HW-1:0] hold_cnt;
`endif

    // DIV is compared live so lowering it below cnt ticks on the next cycle
    assign tick = (cnt >= DIV);

    // Next fill and drain patterns for the latched mode
    always_comb begin
        lo      = Q[H-1:0];
        hi      = Q[WIDTH-1:H];
        fill_q  = {Q[WIDTH-2:0], 1'b1};
        drain_q = Q << 1;
        case (mode_r)
            2'b01: begin
                fill_q  = {1'b1, Q[WIDTH-1:1]};
                drain_q = Q >> 1;
            end
            2'b10: begin
                drain_q = Q >> 1;
            end
            2'b11: begin
                fill_q  = {(hi << 1) | HALF_ONE, (lo >> 1) | HALF_TOP};
                drain_q = {hi << 1, lo >> 1};
            end
            default: ;
        endcase
    end

    // Sequencer: prescaler, state machine, LED register and event pulses
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            mode_r      <= 2'b00;
            cnt         <= '0;
            Q           <= '0;
            FULL_PULSE  <= 1'b0;
            EMPTY_PULSE <= 1'b0;
`ifdef LED_FILL_HOLD_EN
            hold_cnt    <= '0;
`endif
        end else begin
            FULL_PULSE  <= 1'b0;
            EMPTY_PULSE <= 1'b0;
            if (!EN) begin
                state <= S_IDLE;
                cnt   <= '0;
                Q     <= '0;
`ifdef LED_FILL_HOLD_EN
                hold_cnt <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt    <= '0;
                        Q      <= '0;
                        mode_r <= MODE;
                        state  <= S_FILL;
                    end
                    S_FILL: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) begin
                            Q <= fill_q;
                            if (&fill_q) begin
                                FULL_PULSE <= 1'b1;
`ifdef LED_FILL_HOLD_EN
                                hold_cnt   <= '0;
                                state      <= S_HOLD;
`else
                                state      <= S_DRAIN;
`endif
                            end
                        end
                    end
`ifdef LED_FILL_HOLD_EN
                    S_HOLD: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) begin
                            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                                // last dwell tick doubles as the first drain step
                                Q <= drain_q;
                                if (drain_q == '0) begin
                                    EMPTY_PULSE <= 1'b1;
                                    mode_r      <= MODE;
                                    state       <= S_FILL;
                                end else begin
                                    state <= S_DRAIN;
                                end
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
`endif
                    S_DRAIN: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) begin
                            Q <= drain_q;
                            if (drain_q == '0) begin
                                EMPTY_PULSE <= 1'b1;
                                mode_r      <= MODE;
                                state       <= S_FILL;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        Q     <= '0;
                    end
                endcase
            end
        end
    end

endmodule
